// File: rtl/pattern_classifier_pkg.sv
// Shared types and helpers for the pattern classifier pipeline.
// Result bundle width follows the default 16-bit word with a 12-bit high span.
package pattern_classifier_pkg;

  localparam int PCL_TW    = 12;
  localparam int PCL_LVL_W = $clog2(PCL_TW + 1);

  typedef struct packed {
    logic                 ones;
    logic                 zero;
    logic                 thermo;
    logic [PCL_LVL_W-1:0] level;
  } pcl_result_t;

  // Saturating increment for counters up to 32 bits wide.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] cnt,
    input int unsigned w
  );
    logic [31:0] max;
    max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/pcl_span_reduce.sv
// Stage-1 partials: low-span AND, high-span OR and the
// thermometer violation vector (a one sitting above a zero).
module pcl_span_reduce #(
  parameter int WIDTH   = 16,
  parameter int ONES_HI = 11,
  parameter int ZERO_LO = 4,
  localparam int TW     = WIDTH - ZERO_LO
) (
  input  logic [WIDTH-1:0] data,
  output logic             and_lo,
  output logic             or_hi,
  output logic [TW-1:0]    hi,
  output logic [TW-2:0]    viol
);

  assign hi     = data[WIDTH-1:ZERO_LO];
  assign and_lo = &data[ONES_HI:0];
  assign or_hi  = |hi;
  assign viol   = hi[TW-1:1] & ~hi[TW-2:0];

endmodule

// File: rtl/pattern_classifier_pipe.sv
// Two-stage elastic word classifier with saturating per-class counters.
// S1 holds span partials, S2 holds the reduced result presented downstream.
module pattern_classifier_pipe
  import pattern_classifier_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ONES_HI = 11,
  parameter int ZERO_LO = 4,
  parameter int CNT_W   = 16,
  localparam int TW     = WIDTH - ZERO_LO,
  localparam int LW     = $clog2(TW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ones,
  output logic             out_zero,
  output logic             out_thermo,
  output logic [LW-1:0]    out_level,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_ones,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_bad
);

  logic          p_and;
  logic          p_or;
  logic [TW-1:0] p_hi;
  logic [TW-2:0] p_viol;

  pcl_span_reduce #(
    .WIDTH  (WIDTH),
    .ONES_HI(ONES_HI),
    .ZERO_LO(ZERO_LO)
  ) u_reduce (
    .data  (in_data),
    .and_lo(p_and),
    .or_hi (p_or),
    .hi    (p_hi),
    .viol  (p_viol)
  );

  logic          s1_v_q, s1_v_d;
  logic          s1_and_q, s1_and_d;
  logic          s1_or_q, s1_or_d;
  logic [TW-1:0] s1_hi_q, s1_hi_d;
  logic [TW-2:0] s1_viol_q, s1_viol_d;

  logic        s2_v_q, s2_v_d;
  pcl_result_t res_q, res_d;

  logic [CNT_W-1:0] c_ones_q, c_ones_d;
  logic [CNT_W-1:0] c_zero_q, c_zero_d;
  logic [CNT_W-1:0] c_bad_q, c_bad_d;

  logic          s2_adv;
  logic          s1_adv;
  logic          out_hs;
  logic          thermo;
  logic [LW-1:0] pop;

  assign s2_adv = !s2_v_q || out_ready;
  assign s1_adv = !s1_v_q || s2_adv;
  assign out_hs = s2_v_q && out_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < TW; i++) begin
      pop = pop + LW'(s1_hi_q[i]);
    end
    thermo = ~|s1_viol_q;
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_and_d  = s1_and_q;
    s1_or_d   = s1_or_q;
    s1_hi_d   = s1_hi_q;
    s1_viol_d = s1_viol_q;
    s2_v_d    = s2_v_q;
    res_d     = res_q;
    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_and_d  = p_and;
        s1_or_d   = p_or;
        s1_hi_d   = p_hi;
        s1_viol_d = p_viol;
      end
    end
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        res_d.ones   = s1_and_q;
        res_d.zero   = ~s1_or_q;
        res_d.thermo = thermo;
        res_d.level  = PCL_LVL_W'(thermo ? pop : '0);
      end
    end
  end

  // Clear takes priority over a same-cycle handshake.
  always_comb begin
    c_ones_d = c_ones_q;
    c_zero_d = c_zero_q;
    c_bad_d  = c_bad_q;
    if (clr_cnt) begin
      c_ones_d = '0;
      c_zero_d = '0;
      c_bad_d  = '0;
    end else if (out_hs) begin
      if (res_q.ones)
        c_ones_d = CNT_W'(sat_inc(32'(c_ones_q), CNT_W));
      if (res_q.zero)
        c_zero_d = CNT_W'(sat_inc(32'(c_zero_q), CNT_W));
      if (!res_q.thermo)
        c_bad_d = CNT_W'(sat_inc(32'(c_bad_q), CNT_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_and_q  <= 1'b0;
      s1_or_q   <= 1'b0;
      s1_hi_q   <= '0;
      s1_viol_q <= '0;
      s2_v_q    <= 1'b0;
      res_q     <= '0;
      c_ones_q  <= '0;
      c_zero_q  <= '0;
      c_bad_q   <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_and_q  <= s1_and_d;
      s1_or_q   <= s1_or_d;
      s1_hi_q   <= s1_hi_d;
      s1_viol_q <= s1_viol_d;
      s2_v_q    <= s2_v_d;
      res_q     <= res_d;
      c_ones_q  <= c_ones_d;
      c_zero_q  <= c_zero_d;
      c_bad_q   <= c_bad_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = s2_v_q;
  assign out_ones   = res_q.ones;
  assign out_zero   = res_q.zero;
  assign out_thermo = res_q.thermo;
  assign out_level  = LW'(res_q.level);
  assign cnt_ones   = c_ones_q;
  assign cnt_zero   = c_zero_q;
  assign cnt_bad    = c_bad_q;

endmodule

// File: tb/tb_pattern_classifier_pipe.sv
// Randomised and directed bench for pattern_classifier_pipe
// against a queue-based reference model.
module tb_pattern_classifier_pipe;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_ones;
  logic        out_zero;
  logic        out_thermo;
  logic [3:0]  out_level;
  logic        clr_cnt = 1'b0;
  logic [3:0]  cnt_ones;
  logic [3:0]  cnt_zero;
  logic [3:0]  cnt_bad;

  pattern_classifier_pipe #(
    .WIDTH  (16),
    .ONES_HI(11),
    .ZERO_LO(4),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ones  (out_ones),
    .out_zero  (out_zero),
    .out_thermo(out_thermo),
    .out_level (out_level),
    .clr_cnt   (clr_cnt),
    .cnt_ones  (cnt_ones),
    .cnt_zero  (cnt_zero),
    .cnt_bad   (cnt_bad)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] q[$];
  int         m_ones = 0;
  int         m_zero = 0;
  int         m_bad  = 0;
  bit         saw_in;
  bit         saw_out;
  logic [6:0] last_res;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ones, zero, thermo, level} from counting bits of the word
  function automatic logic [6:0] ref_res(input logic [15:0] w);
    int         pop;
    bit         ones;
    bit         th;
    logic [11:0] hi;
    pop  = 0;
    ones = 1'b1;
    hi   = w[15:4];
    for (int i = 0; i <= 11; i++) if (!w[i]) ones = 1'b0;
    for (int i = 0; i < 12; i++) pop += int'(hi[i]);
    th = (int'(hi) == (1 << pop) - 1);
    return {ones, pop == 0, th, th ? 4'(pop) : 4'd0};
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic step();
    logic [6:0] got;
    logic [6:0] e;
    @(negedge clk);
    got = {out_ones, out_zero, out_thermo, out_level};
    chk("cnt_ones", 32'(cnt_ones), 32'(m_ones));
    chk("cnt_zero", 32'(cnt_zero), 32'(m_zero));
    chk("cnt_bad", 32'(cnt_bad), 32'(m_bad));
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
    if (out_valid) begin
      if (q.size() == 0) chk("spurious", 32'(out_valid), 32'd0);
      else chk("res", 32'(got), 32'(q[0]));
    end
    saw_in  = in_valid && in_ready;
    saw_out = out_valid && out_ready;
    if (saw_out) begin
      last_res = got;
      e = (q.size() != 0) ? q.pop_front() : 7'd0;
      if (!clr_cnt) begin
        if (e[6]) m_ones = sat(m_ones);
        if (e[5]) m_zero = sat(m_zero);
        if (!e[4]) m_bad = sat(m_bad);
      end
    end
    if (clr_cnt) begin
      m_ones = 0;
      m_zero = 0;
      m_bad  = 0;
    end
    if (saw_in) q.push_back(ref_res(in_data));
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [15:0] w,
                          input logic [6:0] exp);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = w;
    step();
    in_valid = 1'b0;
    n = 1;
    while (n < 10) begin
      step();
      if (saw_out) break;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk(tag, 32'(last_res), 32'(exp));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] words[4];
    int          j;
    int          nout;
    int          pick;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'({cnt_ones, cnt_zero, cnt_bad}), 32'd0);
    @(posedge clk);
    #1;

    send_one("w0fff", 16'h0FFF, 7'b1011000);
    send_one("w000f", 16'h000F, 7'b0110000);
    send_one("w0050", 16'h0050, 7'b0000000);
    chk("cnt_bad1", 32'(cnt_bad), 32'd1);

    // back-to-back stream, one result per cycle
    words[0] = 16'h0001;
    words[1] = 16'h0013;
    words[2] = 16'hFFFF;
    words[3] = 16'h0000;
    out_ready = 1'b1;
    nout = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_data  = words[i % 4];
      step();
      if (saw_out) nout++;
      if (i == 4) chk("ffff_res", 32'(last_res), 32'h5C);
    end
    chk("stream_cnt", 32'(nout), 32'd4);

    // back-pressure: only two words fit while output is stalled
    out_ready = 1'b0;
    j = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (j < 4);
      in_data  = words[j % 4] ^ 16'h0100;
      step();
      if (saw_in) j++;
    end
    chk("bp_accepted", 32'(j), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (j < 4 || q.size() != 0); i++) begin
      in_valid = (j < 4);
      in_data  = words[j % 4] ^ 16'h0100;
      step();
      if (saw_in) j++;
    end
    chk("bp_all_in", 32'(j), 32'd4);
    chk("bp_left", 32'(q.size()), 32'd0);

    // saturation of cnt_ones
    j = 0;
    in_data = 16'hFFFF;
    for (int i = 0; i < 40 && j < 20; i++) begin
      in_valid = 1'b1;
      step();
      if (saw_in) j++;
    end
    drain();
    chk("sat_ones", 32'(cnt_ones), 32'd15);

    // clear coincident with a handshake
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    step();
    step();
    clr_cnt = 1'b1;
    step();
    chk("clr_hs", 32'(saw_out), 32'd1);
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    chk("clr_ones", 32'(cnt_ones), 32'd0);
    drain();

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      clr_cnt   = ($urandom % 32) == 0;
      pick      = int'($urandom % 4);
      case (pick)
        0: in_data = 16'($urandom);
        1: in_data = 16'(((32'd1 << ($urandom % 13)) - 1) << 4) |
                     16'($urandom % 16);
        2: in_data = 16'hFFFF;
        default: in_data = 16'h0FFF ^ 16'($urandom % 2);
      endcase
      step();
    end
    drain();

    // reset with two words in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00F0;
    step();
    in_data = 16'h0FFF;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", 32'({cnt_ones, cnt_zero, cnt_bad}), 32'd0);
    q.delete();
    m_ones = 0;
    m_zero = 0;
    m_bad  = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    send_one("post_rst", 16'h0013, 7'b0010001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
